// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: turns a note event into a glitch-free 50% square wave for a
// piezo buzzer. Pitch changes only land on half-period boundaries, and a release
// always finishes the current high half, so the pin never emits a runt pulse.
module buzzer_tone_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int KEY_ID_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_ID_BITS-1:0] key_id,
  input  logic                   key_is_pressed,
  input  logic                   octave_up,
  input  logic                   octave_down,
  output logic                   buzzer_out,
  output logic                   tone_active
);

  // Half-period = CLK / (2*f). Frequencies are carried as f*10000 so the
  // division stays in integers: CLK*10000 / (2*f*10000) = CLK*5000 / f_x1e4.
  localparam longint NUM   = longint'(CLK_FREQ_HZ) * 64'sd5000;
  localparam int     HP_C  = int'(NUM / 64'sd2616256);
  localparam int     HP_D  = int'(NUM / 64'sd2936648);
  localparam int     HP_E  = int'(NUM / 64'sd3296276);
  localparam int     HP_F  = int'(NUM / 64'sd3492282);
  localparam int     HP_G  = int'(NUM / 64'sd3919954);
  localparam int     HP_A  = int'(NUM / 64'sd4400000);
  localparam int     HP_B  = int'(NUM / 64'sd4938833);
  localparam int     HP_CS = int'(NUM / 64'sd2771826);
  localparam int     HP_DS = int'(NUM / 64'sd3111270);
  localparam int     HP_FS = int'(NUM / 64'sd3699944);
  localparam int     HP_GS = int'(NUM / 64'sd4153047);
  localparam int     HP_AS = int'(NUM / 64'sd4661638);

  // C is the lowest note; the counter must hold its octave-down value.
  localparam int CNT_W = $clog2(2 * HP_C + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TONE    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  logic [KEY_ID_BITS-1:0] key_q;
  logic                   pressed_q;
  logic                   up_q;
  logic                   down_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       hp_q;
  logic                   buzz_q;
  logic                   active_q;

  logic [CNT_W-1:0]       hp0;
  logic [CNT_W-1:0]       tgt_hp;
  logic                   id_ok;
  logic                   valid;
  logic                   last;

  // Register the note event once; every decision uses these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      pressed_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      key_q     <= key_id;
      pressed_q <= key_is_pressed;
      up_q      <= octave_up;
      down_q    <= octave_down;
    end
  end

  // Map the registered key to its middle-octave half-period, then apply octave shift.
  always_comb begin
    hp0   = '0;
    id_ok = 1'b1;
    case (int'(key_q))
      1:       hp0 = CNT_W'(HP_C);
      2:       hp0 = CNT_W'(HP_D);
      3:       hp0 = CNT_W'(HP_E);
      4:       hp0 = CNT_W'(HP_F);
      5:       hp0 = CNT_W'(HP_G);
      6:       hp0 = CNT_W'(HP_A);
      7:       hp0 = CNT_W'(HP_B);
      8:       hp0 = CNT_W'(HP_CS);
      9:       hp0 = CNT_W'(HP_DS);
      10:      hp0 = CNT_W'(HP_FS);
      11:      hp0 = CNT_W'(HP_GS);
      12:      hp0 = CNT_W'(HP_AS);
      default: id_ok = 1'b0;
    endcase
    if (up_q && !down_q) begin
      tgt_hp = hp0 >> 1;
    end else if (down_q && !up_q) begin
      tgt_hp = hp0 << 1;
    end else begin
      tgt_hp = hp0;
    end
    valid = pressed_q && id_ok;
    last  = (cnt_q == hp_q - CNT_W'(1));
  end

  // Tone FSM: the half-period is latched only at entry and at toggles, so a
  // pitch change never stretches or cuts the half in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hp_q     <= '0;
      buzz_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q  <= '0;
          buzz_q <= 1'b0;
          if (valid) begin
            state_q  <= S_TONE;
            buzz_q   <= 1'b1;
            hp_q     <= tgt_hp;
            active_q <= 1'b1;
          end else begin
            active_q <= 1'b0;
          end
        end
        S_TONE, S_RELEASE: begin
          if (valid) begin
            // Re-press during release keeps counting; new pitch waits for the toggle.
            state_q  <= S_TONE;
            active_q <= 1'b1;
            if (last) begin
              buzz_q <= ~buzz_q;
              cnt_q  <= '0;
              hp_q   <= tgt_hp;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (!buzz_q || last) begin
            // Low half may stop at once; a high half stops only at its end.
            state_q  <= S_IDLE;
            active_q <= 1'b0;
            buzz_q   <= 1'b0;
            cnt_q    <= '0;
          end else begin
            state_q  <= S_RELEASE;
            active_q <= 1'b1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          buzz_q   <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign buzzer_out  = buzz_q;
  assign tone_active = active_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Testbench for buzzer_tone_gen, run at a reduced clock frequency so each tone
// is a few hundred cycles. A cycle-level reference model derived from note
// frequencies runs alongside directed, table-driven and random stimulus.
module tb_buzzer_tone_gen;

  localparam int CLK_HZ = 100_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       pr, up, dn;
  logic       buz, act;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int m_key;
  bit m_p, m_u, m_d;
  bit m_out, m_act;
  int m_rem;

  buzzer_tone_gen #(.CLK_FREQ_HZ(CLK_HZ), .KEY_ID_BITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_id        (key),
    .key_is_pressed(pr),
    .octave_up     (up),
    .octave_down   (dn),
    .buzzer_out    (buz),
    .tone_active   (act)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Target half-period from the note frequency and octave request; 0 means rest.
  function automatic int ref_hp(int k, bit u, bit d);
    real f;
    int  hp;
    case (k)
      1: f = 261.6256;  2: f = 293.6648;  3: f = 329.6276;  4: f = 349.2282;
      5: f = 391.9954;  6: f = 440.0;     7: f = 493.8833;  8: f = 277.1826;
      9: f = 311.1270; 10: f = 369.9944; 11: f = 415.3047; 12: f = 466.1638;
      default: return 0;
    endcase
    hp = $rtoi(CLK_HZ / (2.0 * f));
    if (u && !d) return hp / 2;
    if (d && !u) return hp * 2;
    return hp;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_key = 0; m_p = 0; m_u = 0; m_d = 0;
    m_out = 0; m_act = 0; m_rem = 0;
  endtask

  // One clock edge of the behavioural waveform: m_rem counts cycles left in the half.
  task automatic model_step();
    int tgt;
    bit v;
    tgt = ref_hp(m_key, m_u, m_d);
    v   = m_p && (tgt != 0);
    if (!m_act) begin
      if (v) begin
        m_act = 1; m_out = 1; m_rem = tgt;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (v) begin
          m_out = !m_out; m_rem = tgt;
        end else begin
          m_act = 0; m_out = 0;
        end
      end else if (!v && !m_out) begin
        m_act = 0;
      end
    end
    m_key = int'(key); m_p = pr; m_u = up; m_d = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("model_buzzer_out", int'(buz), int'(m_out));
    check("model_tone_active", int'(act), int'(m_act));
  endtask

  task automatic set_in(input int k, input bit p, input bit u, input bit d);
    key = 4'(k); pr = p; up = u; dn = d;
  endtask

  task automatic run_len(input bit lvl, input int lim, output int n);
    n = 0;
    while (buz === lvl && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic go_idle();
    int n;
    set_in(0, 0, 0, 0);
    n = 0;
    while (act !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    tick();
    check("go_idle_active", int'(act), 0);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (buz !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    int key;
    bit p, u, d;
    int hp;   // expected half-period, 0 = no tone expected
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n, n2, hold;

    // Expected half-periods at 100 kHz: floor(100000 / (2 f)), octave shifts applied.
    tbl[0]  = '{6,  1, 0, 0, 113};
    tbl[1]  = '{6,  1, 1, 0, 56};
    tbl[2]  = '{6,  1, 0, 1, 226};
    tbl[3]  = '{6,  1, 1, 1, 113};
    tbl[4]  = '{1,  1, 0, 0, 191};
    tbl[5]  = '{12, 1, 0, 0, 107};
    tbl[6]  = '{7,  1, 1, 0, 50};
    tbl[7]  = '{8,  1, 0, 1, 360};
    tbl[8]  = '{13, 1, 0, 0, 0};
    tbl[9]  = '{0,  1, 0, 0, 0};
    tbl[10] = '{6,  0, 0, 0, 0};

    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();
    repeat (3) tick();
    check("reset_buzzer_out", int'(buz), 0);
    check("reset_tone_active", int'(act), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // basic tone: first rise two edges after the input, then symmetric halves
    set_in(6, 1, 0, 0);
    wait_rise(n);
    check("basic_rise_latency", n, 2);
    check("basic_active", int'(act), 1);
    run_len(1, 1000, n);  check("basic_high", n, 113);
    run_len(0, 1000, n);  check("basic_low", n, 113);
    run_len(1, 1000, n);  check("basic_high2", n, 113);

    // table of notes / octaves / rests
    for (int i = 0; i < 11; i++) begin
      go_idle();
      set_in(tbl[i].key, tbl[i].p, tbl[i].u, tbl[i].d);
      wait_rise(n);
      if (tbl[i].hp != 0) begin
        check($sformatf("tbl%0d_latency", i), n, 2);
        run_len(1, 1000, n);  check($sformatf("tbl%0d_high", i), n, tbl[i].hp);
        run_len(0, 1000, n);  check($sformatf("tbl%0d_low", i), n, tbl[i].hp);
        check($sformatf("tbl%0d_active", i), int'(act), 1);
      end else begin
        check($sformatf("tbl%0d_no_rise", i), int'(buz), 0);
        check($sformatf("tbl%0d_inactive", i), int'(act), 0);
      end
    end

    // pitch change at counter 100 of a high half
    go_idle();
    set_in(6, 1, 0, 0);
    wait_rise(n);
    repeat (100) tick();
    set_in(1, 1, 0, 0);
    run_len(1, 1000, n);
    check("pitch_high_total", 100 + n, 113);
    run_len(0, 1000, n);
    check("pitch_next_low", n, 191);

    // release at counter 100 completes the high half
    go_idle();
    set_in(6, 1, 0, 0);
    wait_rise(n);
    repeat (100) tick();
    set_in(6, 0, 0, 0);
    run_len(1, 1000, n);
    check("release_high_total", 100 + n, 113);
    check("release_inactive", int'(act), 0);
    repeat (5) tick();
    check("release_stays_low", int'(buz), 0);

    // re-press during release continues the waveform with no gap
    go_idle();
    set_in(6, 1, 0, 1);
    wait_rise(n);
    repeat (100) tick();
    set_in(6, 0, 0, 1);
    repeat (100) tick();
    check("repress_release_active", int'(act), 1);
    set_in(6, 1, 0, 1);
    run_len(1, 1000, n);
    check("repress_high_total", 200 + n, 226);
    check("repress_active", int'(act), 1);
    run_len(0, 1000, n2);
    check("repress_low", n2, 226);

    // rest while low stops on the edge after the input is registered
    go_idle();
    set_in(6, 1, 0, 0);
    wait_rise(n);
    run_len(1, 1000, n);
    repeat (10) tick();
    set_in(0, 1, 0, 0);
    n = 0;
    while (act !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("rest_low_stop_edges", n, 2);
    check("rest_low_buzzer", int'(buz), 0);

    // asynchronous reset mid-tone
    go_idle();
    set_in(6, 1, 0, 0);
    wait_rise(n);
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_buzzer", int'(buz), 0);
    check("async_rst_active", int'(act), 0);
    model_reset();
    set_in(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_rst_buzzer", int'(buz), 0);
    check("post_rst_active", int'(act), 0);

    // random note events against the reference model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        set_in($urandom_range(0, 15), ($urandom_range(0, 4) != 0),
               $urandom_range(0, 1), $urandom_range(0, 1));
        hold = $urandom_range(1, 300);
      end
      hold--;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
